// File: rtl/cpu_trace_capture.sv
// Retirement-trace recorder: watches the CPU control state for instruction-fetch
// entries and queues one {PC, instruction, cycle count} record per completed instruction.
module cpu_trace_capture #(
   parameter int          DEPTH       = 16,
   parameter logic [3:0]  FETCH_STATE = 4'd0
) (
   input  logic                     Clk,
   input  logic                     Reset_n,
   input  logic                     Enable,
   input  logic [3:0]               t_State,
   input  logic [31:0]              t_CurrentPC,
   input  logic [31:0]              t_LatchedInstr,
   output logic                     Rd_Valid,
   input  logic                     Rd_Ready,
   output logic [31:0]              Rd_PC,
   output logic [31:0]              Rd_Instr,
   output logic [7:0]               Rd_Cycles,
   output logic [$clog2(DEPTH):0]   Count,
   output logic                     Full,
   output logic [15:0]              Dropped
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   typedef enum logic [1:0] {IDLE, ARM, TRACK} state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [7:0]  cyc;
   } rec_t;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   state_t         state_q, state_d;
   logic [3:0]     prev_state_q, prev_state_d;
   logic           prev_valid_q, prev_valid_d;
   logic [31:0]    cur_pc_q, cur_pc_d;
   logic [31:0]    cur_instr_q, cur_instr_d;
   logic [7:0]     cyc_q, cyc_d;
   logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]  count_q, count_d;
   logic           full_q, full_d;
   logic [15:0]    dropped_q, dropped_d;
   rec_t           mem_q [DEPTH];

   logic           fetch_entry;
   logic           push_req;
   logic           pop;
   logic           do_push;
   rec_t           push_rec;
   rec_t           head;

   // A reset clears prev_valid so a CPU parked in fetch still counts as an entry.
   assign fetch_entry = (t_State == FETCH_STATE) &&
                        (!prev_valid_q || (prev_state_q != FETCH_STATE));

   always_comb begin
      state_d      = state_q;
      cur_pc_d     = cur_pc_q;
      cur_instr_d  = cur_instr_q;
      cyc_d        = cyc_q;
      push_req     = 1'b0;
      prev_state_d = t_State;
      prev_valid_d = 1'b1;
      push_rec     = '{pc: cur_pc_q, instr: cur_instr_q, cyc: cyc_q};
      case (state_q)
         IDLE: begin
            if (Enable) state_d = ARM;
         end
         ARM: begin
            if (!Enable) begin
               state_d = IDLE;
            end else if (fetch_entry) begin
               state_d  = TRACK;
               cur_pc_d = t_CurrentPC;
               cyc_d    = 8'd1;
            end
         end
         TRACK: begin
            if (!Enable) begin
               state_d = IDLE;
            end else begin
               if (t_State != FETCH_STATE) cur_instr_d = t_LatchedInstr;
               cyc_d = sat_inc8(cyc_q);
               // The record closes before this fetch cycle is counted.
               if (fetch_entry) begin
                  push_req = 1'b1;
                  cur_pc_d = t_CurrentPC;
                  cyc_d    = 8'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      pop       = (count_q != '0) && Rd_Ready;
      do_push   = push_req && (!full_q || pop);
      wr_ptr_d  = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d   = count_q;
      case ({do_push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      full_d    = (count_d == FULL_CNT);
      dropped_d = (push_req && !do_push) ? sat_inc16(dropped_q) : dropped_q;
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q      <= IDLE;
         prev_state_q <= 4'd0;
         prev_valid_q <= 1'b0;
         cur_pc_q     <= '0;
         cur_instr_q  <= '0;
         cyc_q        <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         full_q       <= 1'b0;
         dropped_q    <= '0;
      end else begin
         state_q      <= state_d;
         prev_state_q <= prev_state_d;
         prev_valid_q <= prev_valid_d;
         cur_pc_q     <= cur_pc_d;
         cur_instr_q  <= cur_instr_d;
         cyc_q        <= cyc_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         full_q       <= full_d;
         dropped_q    <= dropped_d;
      end
   end

   // Storage needs no reset: an empty FIFO masks the read outputs to zero.
   always_ff @(posedge Clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_rec;
   end

   assign head      = mem_q[rd_ptr_q];
   assign Rd_Valid  = (count_q != '0);
   assign Rd_PC     = Rd_Valid ? head.pc    : '0;
   assign Rd_Instr  = Rd_Valid ? head.instr : '0;
   assign Rd_Cycles = Rd_Valid ? head.cyc   : '0;
   assign Count     = count_q;
   assign Full      = full_q;
   assign Dropped   = dropped_q;

endmodule

// File: tb/tb_cpu_trace_capture.sv
// Bench for cpu_trace_capture: instruction-level stimulus feeds an expected-record
// queue; a negedge monitor compares every handshake and the occupancy outputs.
module tb_cpu_trace_capture;

   localparam int DEPTH = 16;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [7:0]  cyc;
   } rec_t;

   logic        Clk;
   logic        Reset_n;
   logic        Enable;
   logic [3:0]  t_State;
   logic [31:0] t_CurrentPC;
   logic [31:0] t_LatchedInstr;
   logic        Rd_Valid;
   logic        Rd_Ready;
   logic [31:0] Rd_PC;
   logic [31:0] Rd_Instr;
   logic [7:0]  Rd_Cycles;
   logic [4:0]  Count;
   logic        Full;
   logic [15:0] Dropped;

   cpu_trace_capture #(.DEPTH(DEPTH), .FETCH_STATE(4'd0)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .Enable(Enable), .t_State(t_State),
      .t_CurrentPC(t_CurrentPC), .t_LatchedInstr(t_LatchedInstr),
      .Rd_Valid(Rd_Valid), .Rd_Ready(Rd_Ready), .Rd_PC(Rd_PC),
      .Rd_Instr(Rd_Instr), .Rd_Cycles(Rd_Cycles), .Count(Count),
      .Full(Full), .Dropped(Dropped)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   int   total = 0;
   int   bad   = 0;

   // Reference model state
   rec_t exp_q[$];
   int   exp_drops = 0;
   logic pend_push = 1'b0;
   rec_t pend_rec;
   logic tracking  = 1'b0;
   logic en_prev   = 1'b0;
   logic pv        = 1'b0;
   logic [3:0] ps  = 4'd0;
   logic [31:0] m_pc = '0;
   logic [31:0] m_instr = '0;
   int   m_cyc = 0;
   logic en_cur = 1'b0;
   int   rdy_mode = 0;   // 0 low, 1 high, 2 random, 3 high only on fetch-entry cycles

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // One CPU cycle: apply inputs, advance the model by the capture rules, step the clock.
   task automatic cyc(input logic [3:0] st, input logic [31:0] pc, input logic [31:0] ins);
      logic fe;
      fe = (st == 4'd0) && (!pv || ps != 4'd0);
      Enable = en_cur;
      t_State = st;
      t_CurrentPC = pc;
      t_LatchedInstr = ins;
      case (rdy_mode)
         0:       Rd_Ready = 1'b0;
         1:       Rd_Ready = 1'b1;
         2:       Rd_Ready = 1'($urandom_range(0, 1));
         default: Rd_Ready = fe;
      endcase
      if (!en_cur) begin
         tracking = 1'b0;
      end else if (en_prev) begin
         if (fe) begin
            if (tracking) begin
               pend_rec  = '{pc: m_pc, instr: m_instr, cyc: (m_cyc > 255) ? 8'd255 : 8'(m_cyc)};
               pend_push = 1'b1;
            end
            tracking = 1'b1;
            m_pc  = pc;
            m_cyc = 1;
         end else if (tracking) begin
            m_cyc++;
            if (st != 4'd0) m_instr = ins;
         end
      end
      en_prev = en_cur;
      pv = 1'b1;
      ps = st;
      @(posedge Clk);
      #1;
   endtask

   task automatic do_instr(input logic [31:0] pc, input logic [31:0] ins, input int nf, input int nn);
      for (int i = 0; i < nf; i++) cyc(4'd0, pc, $urandom);
      for (int i = 0; i < nn; i++)
         cyc(4'($urandom_range(1, 15)), $urandom, (i == nn - 1) ? ins : $urandom);
   endtask

   task automatic hold(input int n);
      for (int i = 0; i < n; i++) cyc(4'd5, $urandom, $urandom);
   endtask

   // Monitor: occupancy checks, then the handshake, then the pending push.
   always @(negedge Clk) begin
      if (Reset_n) begin
         chk("count", 32'(Count), 32'(exp_q.size()));
         chk("full", 32'(Full), 32'(exp_q.size() == DEPTH));
         chk("rd_valid", 32'(Rd_Valid), 32'(exp_q.size() != 0));
         chk("dropped", 32'(Dropped), 32'(exp_drops));
         if (Rd_Valid && Rd_Ready) begin
            if (exp_q.size() == 0) begin
               chk("pop_on_empty", 32'(Rd_Valid), 32'd0);
            end else begin
               chk("rd_pc", Rd_PC, exp_q[0].pc);
               chk("rd_instr", Rd_Instr, exp_q[0].instr);
               chk("rd_cycles", 32'(Rd_Cycles), 32'(exp_q[0].cyc));
               void'(exp_q.pop_front());
            end
         end
         if (pend_push) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(pend_rec);
            else if (exp_drops != 16'hFFFF) exp_drops++;
            pend_push = 1'b0;
         end
      end
   end

   initial begin
      Reset_n = 1'b0;
      Enable = 1'b0;
      Rd_Ready = 1'b0;
      t_State = 4'd3;
      t_CurrentPC = '0;
      t_LatchedInstr = '0;

      cyc(4'd0, 32'h40, $urandom);
      cyc(4'd2, $urandom, $urandom);
      chk("reset_rd_valid", 32'(Rd_Valid), 32'd0);
      chk("reset_count", 32'(Count), 32'd0);
      chk("reset_dropped", 32'(Dropped), 32'd0);
      chk("reset_full", 32'(Full), 32'd0);
      chk("reset_rd_pc", Rd_PC, 32'd0);
      Reset_n = 1'b1;
      pv = 1'b0;
      en_prev = 1'b0;

      // CPU runs while capture is disabled
      for (int i = 0; i < 3; i++) do_instr(32'h1000 + 32'(i * 4), $urandom, 1, 3);

      // First record
      en_cur = 1'b1;
      hold(1);
      do_instr(32'h0000_0004, 32'h2008_0005, 1, 3);
      chk("first_before_valid", 32'(Rd_Valid), 32'd0);
      do_instr(32'h0000_0008, $urandom, 1, 3);
      chk("first_valid", 32'(Rd_Valid), 32'd1);
      chk("first_pc", Rd_PC, 32'h0000_0004);
      chk("first_instr", Rd_Instr, 32'h2008_0005);
      chk("first_cycles", 32'(Rd_Cycles), 32'd4);
      chk("first_count", 32'(Count), 32'd1);

      // Overflow: records for PCs 4..64 fit, the one for 68 is dropped
      for (int pc = 12; pc <= 72; pc += 4) do_instr(32'(pc), $urandom, 1, 2 + $urandom_range(0, 2));
      chk("ovf_full", 32'(Full), 32'd1);
      chk("ovf_count", 32'(Count), 32'd16);
      chk("ovf_dropped", 32'(Dropped), 32'd1);
      rdy_mode = 1;
      hold(18);
      chk("drain_valid", 32'(Rd_Valid), 32'd0);

      // Push and pop together while full
      rdy_mode = 0;
      for (int i = 0; i < 16; i++) do_instr(32'h100 + 32'(i * 4), $urandom, 1, 2);
      chk("refill_full", 32'(Full), 32'd1);
      rdy_mode = 3;
      do_instr(32'h140, $urandom, 1, 3);
      chk("pushpop_count", 32'(Count), 32'd16);
      chk("pushpop_dropped", 32'(Dropped), 32'd1);
      rdy_mode = 1;
      hold(18);

      // Random instruction stream with enable glitches
      rdy_mode = 2;
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            en_cur = 1'b0;
            hold(2);
            en_cur = 1'b1;
            hold(1);
         end
         do_instr($urandom, $urandom, $urandom_range(1, 3), $urandom_range(1, 8));
      end

      // Cycle-count saturation
      rdy_mode = 1;
      hold(20);
      do_instr(32'h0000_0ABC, 32'hDEAD_BEEF, 1, 300);
      rdy_mode = 0;
      do_instr(32'h0000_0AC0, $urandom, 1, 3);
      chk("sat_count", 32'(Count), 32'd1);
      chk("sat_pc", Rd_PC, 32'h0000_0ABC);
      chk("sat_cycles", 32'(Rd_Cycles), 32'd255);

      // Asynchronous reset with a record pending and an instruction in flight
      #2;
      Reset_n = 1'b0;
      #1;
      chk("async_rd_valid", 32'(Rd_Valid), 32'd0);
      chk("async_count", 32'(Count), 32'd0);
      chk("async_dropped", 32'(Dropped), 32'd0);
      exp_q.delete();
      exp_drops = 0;
      pend_push = 1'b0;
      tracking = 1'b0;
      @(posedge Clk);
      #1;
      Reset_n = 1'b1;
      pv = 1'b0;
      en_prev = 1'b0;
      do_instr(32'h200, $urandom, 1, 3);
      do_instr(32'h204, $urandom, 1, 3);
      chk("post_reset_count", 32'(Count), 32'd0);
      do_instr(32'h208, $urandom, 2, 3);
      chk("post_reset_pc", Rd_PC, 32'h204);
      rdy_mode = 1;
      hold(5);
      chk("final_count", 32'(Count), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cpu_trace_capture.md
Name: cpu_trace_capture

Overview:
- Retirement-trace recorder on the CPU debug outputs (t_State, t_CurrentPC, t_LatchedInstr). Detects instruction boundaries and buffers one record per completed instruction {PC, instruction word, cycle count} in a FIFO.
- A valid/ready read port drains records, giving a hardware view of execution that the bench otherwise reconstructs by waveform.
- Sits beside the CPU and is clocked by the same Clk.

Parameters:
- DEPTH, 16, FIFO entries; power of two, at least 2.
- FETCH_STATE, 4'd0, t_State encoding of the instruction-fetch state.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset_n  input  1  asynchronous active-low reset.
- Enable  input  1  capture enable; low = no new records, read port still drains.
- t_State  input  4  CPU control state.
- t_CurrentPC  input  32  CPU program counter.
- t_LatchedInstr  input  32  CPU instruction register.
- Rd_Valid  output  1  head record available.
- Rd_Ready  input  1  consumer accepts head record.
- Rd_PC  output  32  head record PC.
- Rd_Instr  output  32  head record instruction.
- Rd_Cycles  output  8  head record cycle count.
- Count  output  $clog2(DEPTH)+1  occupancy, 0..DEPTH.
- Full  output  1  Count==DEPTH.
- Dropped  output  16  records lost to overflow, saturating.

Behaviour:
- Reset (asynchronous, Reset_n low): FIFO empty; Rd_Valid=0; Rd_PC, Rd_Instr, Rd_Cycles, Count, Dropped all 0; Full=0; FSM=IDLE; prev_valid=0.
- Fetch entry (combinational): t_State==FETCH_STATE && (!prev_valid || prev_state!=FETCH_STATE).
  - prev_state and prev_valid register t_State every cycle; prev_valid is set 1 on the first cycle out of reset.
- FSM:
  - IDLE: go to ARM when Enable=1.
  - ARM: on fetch entry, go to TRACK; latch cur_pc=t_CurrentPC and cyc=1; no push.
  - TRACK, every cycle:
    - if t_State!=FETCH_STATE, cur_instr <= t_LatchedInstr, so the last non-fetch cycle's value is kept;
    - cyc increments, saturating at 255.
  - TRACK, on fetch entry:
    - push {cur_pc, cur_instr, cyc} (cyc = cycles from the previous fetch entry up to but not including this cycle);
    - then re-latch cur_pc=t_CurrentPC and cyc=1.
  - Enable=0 in ARM or TRACK: go to IDLE immediately; the in-flight instruction is discarded, not pushed.
- FIFO and read port:
  - Circular buffer with wrap-around pointers.
  - Rd_* show the head entry combinationally from storage; Rd_Valid = Count!=0.
  - Pop when Rd_Valid && Rd_Ready. Rd_Ready with an empty FIFO is a no-op.
  - Push latency: a record pushed at edge N is visible on Rd_* after edge N; Rd_Valid rises the same cycle.
  - Push and pop in the same cycle: Count unchanged; allowed when Full, since the pop frees the slot first.
  - Push when Full with no pop: record dropped; Dropped increments, saturating at 16'hFFFF; FSM still re-latches for the next instruction.
- Reset_n low mid-operation: all records and Dropped cleared at once; the FSM restarts in IDLE.
- Count and Full are registered and consistent with the pointers every cycle.

Test Plan:
- Reset_n=0 for 2 cycles, then 1 with Enable=0 and the CPU running -> Rd_Valid=0, Count=0, Dropped=0 throughout.
- Enable=1. Drive states 0,1,2,3 (PC 0x0000_0004 at the first fetch, instr 0x2008_0005) then 0 again -> one record {PC=0x0000_0004, Instr=0x2008_0005, Cycles=4}; Rd_Valid rises the cycle after the second fetch entry; Count=1.
- Drive 17 instructions with Rd_Ready=0 and DEPTH=16 -> Full=1, Count=16, Dropped=1. Assert Rd_Ready for 16 cycles -> the records drain in order, matching PCs 4,8,...,64; Rd_Valid=0 afterwards.
- With Full=1, hold Rd_Ready=1 during a boundary -> Count stays 16, Dropped unchanged, the new record sits at the tail after wrap-around.
- Hold a non-fetch state for 300 cycles -> Cycles=255, saturated.
- Pull Reset_n low while a record is pending and in TRACK -> asynchronous clear without waiting for a Clk edge: Rd_Valid=0, Count=0, Dropped=0; after release, the first fetch entry produces no record.
